// File: rtl/uart_cdc.sv
`timescale 1ns/1ps
// uart_cdc: UART endpoint for the CPU FIFO bridge byte-stream interface.
// The "in" stream is serialised onto uart_tx_o. Bytes received on uart_rx_i
// are buffered in a show-ahead FIFO and presented on the "out" stream.
// Optional feature macro: UART_CDC_PARITY_EN (even parity bit after bit 7).
// When undefined, frames are 8N1 and no parity logic is built.
module uart_cdc #(
   parameter int CLK_HZ   = 12000000,
   parameter int BAUD     = 115200,
   parameter int RX_DEPTH = 4
) (
   input  logic       clk_i,
   input  logic       rstn_i,
   input  logic [7:0] in_data_i,
   input  logic       in_valid_i,
   output logic       in_ready_o,
   output logic [7:0] out_data_o,
   output logic       out_valid_o,
   input  logic       out_ready_i,
   output logic       uart_tx_o,
   input  logic       uart_rx_i,
   output logic       rx_overrun_o,
   output logic       rx_frame_err_o
);

   localparam int DIV = CLK_HZ / BAUD;
   localparam int CW  = (DIV >= 2) ? $clog2(DIV) : 1;
   localparam int AW  = (RX_DEPTH >= 2) ? $clog2(RX_DEPTH) : 1;

   localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'((DIV / 2) - 1);
   localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

   // Configuration sanity: the baud divider must leave room for mid-bit sampling
   if (DIV < 8) begin : g_div_check
      $error("uart_cdc: CLK_HZ/BAUD must be at least 8");
   end
   if ((RX_DEPTH < 2) || ((RX_DEPTH & (RX_DEPTH - 1)) != 0)) begin : g_depth_check
      $error("uart_cdc: RX_DEPTH must be a power of 2 and at least 2");
   end

`ifdef UART_CDC_PARITY_EN
   // Even parity: the parity bit makes the total count of ones even
   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction
`endif

   typedef enum logic [2:0] {
      TX_IDLE  = 3'd0,
      TX_START = 3'd1,
      TX_DATA  = 3'd2,
      TX_PAR   = 3'd3,
      TX_STOP  = 3'd4
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE  = 3'd0,
      RX_START = 3'd1,
      RX_DATA  = 3'd2,
      RX_PAR   = 3'd3,
      RX_STOP  = 3'd4
   } rx_state_t;

   // ------------------------------------------------------------------
   // Transmitter
   // ------------------------------------------------------------------
   tx_state_t       tx_state_r, tx_state_s;
   logic [CW-1:0]   tx_cnt_r, tx_cnt_s;
   logic [2:0]      tx_bit_r, tx_bit_s;
   logic [7:0]      tx_shift_r, tx_shift_s;
   logic            tx_line_r, tx_line_s;
   logic            in_ready_r, in_ready_s;
   logic            tx_end_s;
`ifdef UART_CDC_PARITY_EN
   logic            tx_par_r, tx_par_s;
`endif

   // TX next-state and next line level; the line value is registered so it
   // changes exactly on bit boundaries and snaps to idle on reset
   always_comb begin
      tx_state_s = tx_state_r;
      tx_cnt_s   = tx_cnt_r;
      tx_bit_s   = tx_bit_r;
      tx_shift_s = tx_shift_r;
      tx_line_s  = tx_line_r;
`ifdef UART_CDC_PARITY_EN
      tx_par_s   = tx_par_r;
`endif
      tx_end_s   = (tx_cnt_r == DIV_LAST);
      case (tx_state_r)
         TX_IDLE: begin
            tx_cnt_s = CNT_ZERO;
            tx_bit_s = 3'd0;
            if (in_valid_i) begin
               tx_shift_s = in_data_i;
`ifdef UART_CDC_PARITY_EN
               tx_par_s   = even_parity(in_data_i);
`endif
               tx_line_s  = 1'b0;
               tx_state_s = TX_START;
            end else begin
               tx_line_s  = 1'b1;
            end
         end
         TX_START: begin
            if (tx_end_s) begin
               tx_cnt_s   = CNT_ZERO;
               tx_bit_s   = 3'd0;
               tx_line_s  = tx_shift_r[0];
               tx_state_s = TX_DATA;
            end else begin
               tx_cnt_s   = tx_cnt_r + CNT_ONE;
            end
         end
         TX_DATA: begin
            if (tx_end_s) begin
               tx_cnt_s = CNT_ZERO;
               if (tx_bit_r == 3'd7) begin
`ifdef UART_CDC_PARITY_EN
                  tx_line_s  = tx_par_r;
                  tx_state_s = TX_PAR;
`else
                  tx_line_s  = 1'b1;
                  tx_state_s = TX_STOP;
`endif
               end else begin
                  tx_bit_s   = tx_bit_r + 3'd1;
                  tx_shift_s = {1'b0, tx_shift_r[7:1]};
                  tx_line_s  = tx_shift_r[1];
               end
            end else begin
               tx_cnt_s = tx_cnt_r + CNT_ONE;
            end
         end
`ifdef UART_CDC_PARITY_EN
         TX_PAR: begin
            if (tx_end_s) begin
               tx_cnt_s   = CNT_ZERO;
               tx_line_s  = 1'b1;
               tx_state_s = TX_STOP;
            end else begin
               tx_cnt_s   = tx_cnt_r + CNT_ONE;
            end
         end
`endif
         TX_STOP: begin
            tx_line_s = 1'b1;
            if (tx_end_s) begin
               tx_cnt_s   = CNT_ZERO;
               tx_state_s = TX_IDLE;
            end else begin
               tx_cnt_s   = tx_cnt_r + CNT_ONE;
            end
         end
         default: begin
            tx_cnt_s   = CNT_ZERO;
            tx_bit_s   = 3'd0;
            tx_line_s  = 1'b1;
            tx_state_s = TX_IDLE;
         end
      endcase
      in_ready_s = (tx_state_s == TX_IDLE);
   end

   // TX state register; reset forces the line idle immediately
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         tx_state_r <= TX_IDLE;
         tx_cnt_r   <= CNT_ZERO;
         tx_bit_r   <= 3'd0;
         tx_shift_r <= 8'h00;
         tx_line_r  <= 1'b1;
         in_ready_r <= 1'b1;
`ifdef UART_CDC_PARITY_EN
         tx_par_r   <= 1'b0;
`endif
      end else begin
         tx_state_r <= tx_state_s;
         tx_cnt_r   <= tx_cnt_s;
         tx_bit_r   <= tx_bit_s;
         tx_shift_r <= tx_shift_s;
         tx_line_r  <= tx_line_s;
         in_ready_r <= in_ready_s;
`ifdef UART_CDC_PARITY_EN
         tx_par_r   <= tx_par_s;
`endif
      end
   end

   // ------------------------------------------------------------------
   // Receiver
   // ------------------------------------------------------------------
   logic            rx_meta_r, rx_sync_r;
   rx_state_t       rx_state_r, rx_state_s;
   logic [CW-1:0]   rx_cnt_r, rx_cnt_s;
   logic [2:0]      rx_bit_r, rx_bit_s;
   logic [7:0]      rx_shift_r, rx_shift_s;
   logic            rx_wait_r, rx_wait_s;
   logic            rx_push_s, rx_ferr_s, rx_par_ok_s;
`ifdef UART_CDC_PARITY_EN
   logic            rx_par_r, rx_par_s;
`endif

   // Two-flop synchroniser for the asynchronous serial input; idles high
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
      end else begin
         rx_meta_r <= uart_rx_i;
         rx_sync_r <= rx_meta_r;
      end
   end

   // RX next-state: half-bit start qualification, then centre sampling.
   // After a bad stop bit the receiver stays disarmed until the line is high.
   always_comb begin
      rx_state_s = rx_state_r;
      rx_cnt_s   = rx_cnt_r;
      rx_bit_s   = rx_bit_r;
      rx_shift_s = rx_shift_r;
      rx_wait_s  = rx_wait_r;
      rx_push_s  = 1'b0;
      rx_ferr_s  = 1'b0;
`ifdef UART_CDC_PARITY_EN
      rx_par_s    = rx_par_r;
      rx_par_ok_s = (even_parity(rx_shift_r) == rx_par_r);
`else
      rx_par_ok_s = 1'b1;
`endif
      case (rx_state_r)
         RX_IDLE: begin
            rx_cnt_s = CNT_ZERO;
            rx_bit_s = 3'd0;
            if (rx_wait_r) begin
               rx_wait_s = !rx_sync_r;
            end else if (!rx_sync_r) begin
               rx_state_s = RX_START;
            end else begin
               rx_state_s = RX_IDLE;
            end
         end
         RX_START: begin
            if (rx_cnt_r == HALF_LAST) begin
               rx_cnt_s = CNT_ZERO;
               if (!rx_sync_r) begin
                  rx_state_s = RX_DATA;
               end else begin
                  rx_state_s = RX_IDLE;
               end
            end else begin
               rx_cnt_s = rx_cnt_r + CNT_ONE;
            end
         end
         RX_DATA: begin
            if (rx_cnt_r == DIV_LAST) begin
               rx_cnt_s   = CNT_ZERO;
               rx_shift_s = {rx_sync_r, rx_shift_r[7:1]};
               if (rx_bit_r == 3'd7) begin
`ifdef UART_CDC_PARITY_EN
                  rx_state_s = RX_PAR;
`else
                  rx_state_s = RX_STOP;
`endif
               end else begin
                  rx_bit_s = rx_bit_r + 3'd1;
               end
            end else begin
               rx_cnt_s = rx_cnt_r + CNT_ONE;
            end
         end
`ifdef UART_CDC_PARITY_EN
         RX_PAR: begin
            if (rx_cnt_r == DIV_LAST) begin
               rx_cnt_s   = CNT_ZERO;
               rx_par_s   = rx_sync_r;
               rx_state_s = RX_STOP;
            end else begin
               rx_cnt_s = rx_cnt_r + CNT_ONE;
            end
         end
`endif
         RX_STOP: begin
            if (rx_cnt_r == DIV_LAST) begin
               rx_cnt_s   = CNT_ZERO;
               rx_state_s = RX_IDLE;
               if (rx_sync_r && rx_par_ok_s) begin
                  rx_push_s = 1'b1;
               end else begin
                  rx_ferr_s = 1'b1;
                  rx_wait_s = !rx_sync_r;
               end
            end else begin
               rx_cnt_s = rx_cnt_r + CNT_ONE;
            end
         end
         default: begin
            rx_cnt_s   = CNT_ZERO;
            rx_bit_s   = 3'd0;
            rx_state_s = RX_IDLE;
         end
      endcase
   end

   // RX state register; reset discards any partially received byte
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rx_state_r <= RX_IDLE;
         rx_cnt_r   <= CNT_ZERO;
         rx_bit_r   <= 3'd0;
         rx_shift_r <= 8'h00;
         rx_wait_r  <= 1'b0;
`ifdef UART_CDC_PARITY_EN
         rx_par_r   <= 1'b0;
`endif
      end else begin
         rx_state_r <= rx_state_s;
         rx_cnt_r   <= rx_cnt_s;
         rx_bit_r   <= rx_bit_s;
         rx_shift_r <= rx_shift_s;
         rx_wait_r  <= rx_wait_s;
`ifdef UART_CDC_PARITY_EN
         rx_par_r   <= rx_par_s;
`endif
      end
   end

   // ------------------------------------------------------------------
   // Receive FIFO (pointers carry an extra wrap bit)
   // ------------------------------------------------------------------
   logic [7:0]  mem_r [RX_DEPTH];
   logic [AW:0] wr_ptr_r, rd_ptr_r;
   logic        empty_s, full_s, pop_s, wen_s, ovr_s;
   logic        ovr_r, ferr_r;

   assign empty_s = (wr_ptr_r == rd_ptr_r);
   assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign pop_s   = !empty_s && out_ready_i;
   // A full FIFO still accepts a byte when the head leaves in the same cycle
   assign wen_s   = rx_push_s && (!full_s || pop_s);
   assign ovr_s   = rx_push_s && full_s && !pop_s;

   // FIFO storage, pointers and the registered error pulses
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < RX_DEPTH; i++) begin
            mem_r[i] <= 8'h00;
         end
         wr_ptr_r <= (AW + 1)'(0);
         rd_ptr_r <= (AW + 1)'(0);
         ovr_r    <= 1'b0;
         ferr_r   <= 1'b0;
      end else begin
         if (wen_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= rx_shift_r;
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         ovr_r  <= ovr_s;
         ferr_r <= rx_ferr_s;
      end
   end

   assign in_ready_o     = in_ready_r;
   assign uart_tx_o      = tx_line_r;
   assign out_valid_o    = !empty_s;
   assign out_data_o     = empty_s ? 8'h00 : mem_r[rd_ptr_r[AW-1:0]];
   assign rx_overrun_o   = ovr_r;
   assign rx_frame_err_o = ferr_r;

endmodule

// File: tb/tb_uart_cdc.sv
`timescale 1ns/1ps
// tb_uart_cdc: directed and randomized bench for uart_cdc at DIV=12.
// Frames are built from the byte with plain bit arithmetic; received bytes
// are tracked in a queue that models a bounded FIFO.
module tb_uart_cdc;

   localparam int DIV   = 12;
   localparam int DEPTH = 4;
`ifdef UART_CDC_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME = NB * DIV;

   logic       clk = 1'b0;
   logic       rstn;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       tx;
   logic       rx;
   logic       ovr;
   logic       ferr;

   int errors = 0;
   int checks = 0;
   int ovr_cnt = 0;
   int ferr_cnt = 0;
   int last_rise = 117;
   logic [7:0] q[$];

   uart_cdc #(.CLK_HZ(12000000), .BAUD(1000000), .RX_DEPTH(DEPTH)) dut (
      .clk_i(clk), .rstn_i(rstn),
      .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .uart_tx_o(tx), .uart_rx_i(rx),
      .rx_overrun_o(ovr), .rx_frame_err_o(ferr)
   );

   always #5 clk = ~clk;

   // Count error pulses away from the active edge
   always @(negedge clk) begin
      if (ovr)  ovr_cnt  <= ovr_cnt + 1;
      if (ferr) ferr_cnt <= ferr_cnt + 1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Line levels of one frame, index 0 = start bit
   function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic stop);
      logic [10:0] f;
      f      = 11'h7FF;
      f[0]   = 1'b0;
      f[8:1] = b;
`ifdef UART_CDC_PARITY_EN
      f[9]   = 1'($countones(b) % 2);
`endif
      f[NB-1] = stop;
      return f;
   endfunction

   // Send one byte; valid stays high through the frame and the data bus is
   // scrambled, which the transmitter must ignore
   task automatic tx_frame(input logic [7:0] b, input bit keep_valid);
      logic [10:0] f;
      int guard;
      f = mk_frame(b, 1'b1);
      guard = 0;
      while (!in_ready && guard < 2000) begin
         tick(1);
         guard++;
      end
      chk("tx_ready_before", 32'(in_ready), 32'd1);
      in_data  = b;
      in_valid = 1'b1;
      tick(1);
      for (int k = 0; k < FRAME; k++) begin
         in_data = 8'($urandom);
         chk("tx_ready_line", 32'({in_ready, tx}), 32'({1'b0, f[k / DIV]}));
         tick(1);
      end
      chk("tx_idle_after", 32'({in_ready, tx}), 32'd3);
      if (!keep_valid) in_valid = 1'b0;
   endtask

   // Drive one frame on the serial input, optionally popping at cycle pop_at
   task automatic rx_frame(input logic [7:0] b, input logic stop, input logic par_bad,
                           input int pop_at);
      logic [10:0] f;
      bit was_empty, frame_ok;
      int f0, o0, rise, exp_ovr;
      f = mk_frame(b, stop);
`ifdef UART_CDC_PARITY_EN
      if (par_bad) f[9] = ~f[9];
`endif
      was_empty = (q.size() == 0);
      frame_ok  = stop && !par_bad;
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      rise = -1;
      for (int k = 0; k < FRAME + 4; k++) begin
         if (k < FRAME) begin
            if (k % DIV == 0) rx = f[k / DIV];
         end else begin
            rx = f[NB-1];
         end
         if (k == pop_at) begin
            chk("rx_pop_valid", 32'(out_valid), 32'd1);
            if (q.size() > 0) chk("rx_pop_data", 32'(out_data), 32'(q[0]));
            out_ready = 1'b1;
         end else begin
            out_ready = 1'b0;
         end
         if (was_empty && rise < 0 && out_valid) rise = k;
         tick(1);
         if (k == pop_at && q.size() > 0) void'(q.pop_front());
      end
      out_ready = 1'b0;
      exp_ovr = 0;
      if (frame_ok) begin
         if (q.size() < DEPTH) q.push_back(b);
         else exp_ovr = 1;
      end
      chk("rx_frame_err_pulses", 32'(ferr_cnt - f0), frame_ok ? 32'd0 : 32'd1);
      chk("rx_overrun_pulses", 32'(ovr_cnt - o0), 32'(exp_ovr));
      if (was_empty && frame_ok) begin
         chk("rx_valid_rise_window", 32'(rise >= 9 * DIV && rise <= FRAME + 3), 32'd1);
         last_rise = rise;
      end
   endtask

   // Pop everything the model expects, in order
   task automatic drain();
      while (q.size() > 0) begin
         chk("drain_valid", 32'(out_valid), 32'd1);
         chk("drain_data", 32'(out_data), 32'(q[0]));
         out_ready = 1'b1;
         tick(1);
         void'(q.pop_front());
      end
      out_ready = 1'b0;
      chk("drain_empty", 32'(out_valid), 32'd0);
   endtask

   initial begin
      int f0;
      logic [7:0] rb;
      rstn = 1'b0; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0; rx = 1'b1;
      tick(3);
      chk("reset_tx", 32'(tx), 32'd1);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_out_data", 32'(out_data), 32'd0);
      chk("reset_pulses", 32'({ovr, ferr}), 32'd0);
      rstn = 1'b1;
      tick(2);

      // Back-to-back transmit: second byte starts one cycle after the first stop
      tx_frame(8'hA5, 1'b1);
      tx_frame(8'h3C, 1'b0);
      tick(5);

      // Single receive into an empty FIFO
      rx_frame(8'h5A, 1'b1, 1'b0, -1);
      drain();

      // Short low glitch is a false start
      f0 = ferr_cnt;
      rx = 1'b0; tick(4); rx = 1'b1; tick(3 * DIV);
      chk("glitch_no_byte", 32'(out_valid), 32'd0);
      chk("glitch_no_err", 32'(ferr_cnt - f0), 32'd0);

      // Overrun on the fifth byte, then ordered read-out
      for (int i = 1; i <= 5; i++) rx_frame(8'(i), 1'b1, 1'b0, -1);
      drain();

      // Push onto a full FIFO in the same cycle as a pop: no overrun
      for (int i = 1; i <= 4; i++) rx_frame(8'(8'h10 * i + i), 1'b1, 1'b0, -1);
      rx_frame(8'h55, 1'b1, 1'b0, last_rise - 1);
      drain();

      // Bad stop bit, line held low, then recovery
      rx_frame(8'h77, 1'b0, 1'b0, -1);
      rx = 1'b0; tick(30); rx = 1'b1; tick(DIV);
      chk("ferr_no_byte", 32'(out_valid), 32'd0);
      rx_frame(8'h11, 1'b1, 1'b0, -1);
      drain();

`ifdef UART_CDC_PARITY_EN
      tx_frame(8'h03, 1'b0);
      rx_frame(8'h07, 1'b1, 1'b1, -1);
      drain();
`endif

      // Randomized traffic in both directions with irregular draining
      for (int i = 0; i < 8; i++) begin
         tx_frame(8'($urandom), 1'b0);
         rb = 8'($urandom);
         rx_frame(rb, 1'b1, 1'b0, -1);
         if ($urandom_range(0, 2) == 0) drain();
      end
      drain();

      // Reset mid-frame in both directions with a byte waiting in the FIFO
      rx_frame(8'h99, 1'b1, 1'b0, -1);
      in_data = 8'h00; in_valid = 1'b1; tick(1); in_valid = 1'b0;
      rx = 1'b0;
      tick(30);
      chk("rst_pre_tx_low", 32'(tx), 32'd0);
      chk("rst_pre_valid", 32'(out_valid), 32'd1);
      f0 = ferr_cnt;
      #1 rstn = 1'b0;
      #1;
      chk("rst_async_tx", 32'(tx), 32'd1);
      q.delete();
      rx = 1'b1;
      tick(2);
      rstn = 1'b1;
      tick(1);
      chk("rst_after_ready", 32'(in_ready), 32'd1);
      chk("rst_after_valid", 32'(out_valid), 32'd0);
      chk("rst_after_data", 32'(out_data), 32'd0);
      tick(FRAME + 10);
      chk("rst_partial_dropped", 32'(out_valid), 32'd0);
      chk("rst_no_err", 32'(ferr_cnt - f0), 32'd0);
      rx_frame(8'hC3, 1'b1, 1'b0, -1);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
